mem_arbiter: RTL and testbench

Shares the single memory port of the NCUT MiniSys core between the instruction-fetch stage and the load/store (MEM) stage. It sequences each access as a fixed-latency, multi-cycle memory transaction and returns read data with a one-cycle acknowledge. It also raises a pipeline stall request while any access is outstanding. It sits between the CPU pipeline and the unified instruction/data RAM inside NCUT_MiniSys.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store with fixed-latency accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_req
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_d;
    logic              busy;

`ifdef MEM_ARB_RR_EN
    // On contention, hand the port to whoever did not win last time.
    assign grant_d = d_req & (~if_req | (last_grant == OWN_I));
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req | d_req) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        addr_q     <= grant_d ? d_addr : if_addr;
                        we_q       <= grant_d & d_we;
                        sel_q      <= grant_d ? d_sel : 4'b1111;
                        wdata_q    <= grant_d ? d_wdata : '0;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        if (!we_q) begin
                            if (owner == OWN_D) d_rdata <= mem_rdata;
                            else                if_rdata <= mem_rdata;
                        end
                        d_ack  <= (owner == OWN_D);
                        if_ack <= (owner == OWN_I);
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign mem_ce    = busy;
    assign mem_we    = busy & we_q;
    assign mem_sel   = busy ? sel_q : '0;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign stall_req = (if_req | d_req) & ~(if_ack | d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_CYCLES=2.
// Arbitration expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the arbiter.
    always_comb begin
        mem_rdata = 32'h0BAD_0BAD;
        if (mem_addr == 32'h100) mem_rdata = 32'h3402_0001;
        if (mem_addr == 32'h200) mem_rdata = 32'h1111_2222;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until an ack and checks bus contents, latency and stall.
    task automatic access(input string tag, input logic exp_d,
                          input logic [31:0] exp_addr, input logic exp_we,
                          input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input int exp_first);
        int n = 0;
        int ce = 0;
        int first = -1;
        bit got = 0;
        bit bus_ok = 1;
        bit stall_ok = 1;
        while (n < 20 && !got) begin
            tick();
            n++;
            if (mem_ce) begin
                ce++;
                if (first < 0) first = n;
                if (mem_addr !== exp_addr || mem_we !== exp_we ||
                    mem_sel !== exp_sel) bus_ok = 0;
                if (exp_we && mem_wdata !== exp_wd) bus_ok = 0;
            end
            if (if_ack | d_ack) got = 1;
            else if (!stall_req) stall_ok = 0;
        end
        check({tag, " ack_seen"}, 32'(got), 32'd1);
        check({tag, " d_ack"}, 32'(d_ack), 32'(exp_d));
        check({tag, " if_ack"}, 32'(if_ack), 32'(!exp_d));
        check({tag, " ce_cycles"}, ce, W + 1);
        check({tag, " grant_at"}, first, exp_first);
        check({tag, " ack_latency"}, n - first, W + 1);
        check({tag, " bus"}, 32'(bus_ok), 32'd1);
        check({tag, " stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, " stall_ack"}, 32'(stall_req), 32'd0);
        check({tag, " mem_ce_ack"}, 32'(mem_ce), 32'd0);
        if (exp_d) check({tag, " d_rdata"}, d_rdata, exp_rd);
        else       check({tag, " if_rdata"}, if_rdata, exp_rd);
    endtask

    initial begin
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_sel   = 4'b1111;
        d_addr  = 32'h200;
        d_wdata = 32'h0;

        // Reset with both requests high
        repeat (3) tick();
        check("rst mem_ce", 32'(mem_ce), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst if_ack", 32'(if_ack), 32'd0);
        check("rst d_ack", 32'(d_ack), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        rst = 1'b1;

        // Contention: data first, fetch after one idle cycle
        access("both_d", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 1);
        d_req = 1'b0;
        access("both_i", 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0,
               32'h3402_0001, 2);
        if_req = 1'b0;
        tick();
        check("if_ack pulse", 32'(if_ack), 32'd0);
        check("if_rdata hold", if_rdata, 32'h3402_0001);
        tick();

        // Lone fetch
        if_req = 1'b1;
        access("fetch", 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0,
               32'h3402_0001, 1);
        if_req = 1'b0;
        repeat (2) tick();

        // Store keeps previous load data
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_sel   = 4'b0011;
        d_addr  = 32'h204;
        d_wdata = 32'hDEAD_BEEF;
        access("store", 1'b1, 32'h204, 1'b1, 4'b0011, 32'hDEAD_BEEF,
               32'h1111_2222, 1);
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (2) tick();

        // Reset in second BUSY cycle
        if_req = 1'b1;
        tick();
        check("pre_rst grant", 32'(mem_ce), 32'd1);
        tick();
        check("pre_rst busy2", 32'(mem_ce), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst mem_ce", 32'(mem_ce), 32'd0);
        check("midrst if_rdata", if_rdata, 32'd0);
        check("midrst d_rdata", d_rdata, 32'd0);
        tick();
        tick();
        check("midrst no_ack", 32'(if_ack | d_ack), 32'd0);
        rst = 1'b1;
        access("reissue", 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0,
               32'h3402_0001, 1);

        // Both requests held continuously
        d_req  = 1'b1;
        d_sel  = 4'b1111;
        d_addr = 32'h200;
        access("arb0", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 2);
`ifdef MEM_ARB_RR_EN
        access("arb1", 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0,
               32'h3402_0001, 2);
        access("arb2", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 2);
        access("arb3", 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0,
               32'h3402_0001, 2);
`else
        access("arb1", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 2);
        access("arb2", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 2);
        access("arb3", 1'b1, 32'h200, 1'b0, 4'b1111, 32'h0,
               32'h1111_2222, 2);
`endif
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
